// File: rtl/leb128_decoder_if.sv
// Byte-in / value-out bundle for the LEB128 immediate decoder.
// Pure wiring: no latency of its own.
// Byte side is valid/ready, value side is valid/ready, error is sticky until clear.
interface leb128_decoder_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        is_signed;
  logic        is_64;
  logic [63:0] out_value;
  logic [3:0]  out_len;
  logic        out_valid;
  logic        out_ready;
  logic        error;
  logic        clear;

  // Decoder side
  modport slave (
    input  in_data, in_valid, is_signed, is_64, out_ready, clear,
    output in_ready, out_value, out_len, out_valid, error
  );

  // Byte source / value consumer side
  modport master (
    output in_data, in_valid, is_signed, is_64, out_ready, clear,
    input  in_ready, out_value, out_len, out_valid, error
  );
endinterface

// File: rtl/leb128_decoder.sv
// LEB128 (unsigned/signed, 32/64-bit) immediate decoder for the instruction byte stream.
// One byte per cycle while accumulating; value appears one cycle after the final byte.
// in_ready drops while a value or error is held; value is held until out_ready, error until clear.
module leb128_decoder #(
  parameter int MAX_BYTES = 10
) (
  input  logic         clk,
  input  logic         reset,
  leb128_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_ACCUM  = 2'd0,
    S_OUTPUT = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  // Index of the last byte a 64-bit encoding may use (32-bit is always index 4).
  localparam logic [3:0] LAST64 = 4'(MAX_BYTES - 1);

  state_t      state_q;
  logic [63:0] acc_q;
  logic [3:0]  cnt_q;
  logic        sgn_q;
  logic        w64_q;
  logic [63:0] out_value_q;
  logic [3:0]  out_len_q;
  logic        out_valid_q;
  logic        error_q;
  logic        in_ready_q;

  logic        fire;
  logic        sgn_c;
  logic        w64_c;
  logic [6:0]  shamt_c;
  logic [6:0]  fill_sh_c;
  logic [3:0]  len_d;
  logic [63:0] acc_d;
  logic [63:0] ext_c;
  logic [63:0] value_d;
  logic        last_c;
  logic        final_c;
  logic        bad_c;

  // in_ready is registered and only ever high in S_ACCUM, so this is the byte handshake.
  assign fire = bus.in_valid && in_ready_q;

  // Fold the incoming byte into the accumulator and decide final value / legality.
  always_comb begin
    // Mode bits come from the inputs on the first byte, from the latched copies afterwards.
    sgn_c     = (cnt_q == 4'd0) ? bus.is_signed : sgn_q;
    w64_c     = (cnt_q == 4'd0) ? bus.is_64     : w64_q;
    shamt_c   = 7'(cnt_q) * 7'd7;
    len_d     = cnt_q + 4'd1;
    fill_sh_c = 7'(len_d) * 7'd7;
    // Bits of byte 9 beyond bit 63 fall off the top here; the legality check covers them.
    acc_d     = acc_q | ({57'd0, bus.in_data[6:0]} << shamt_c);

    // Sign fill above the last payload bit; a shift of 64 or more yields no fill.
    ext_c = acc_d;
    if (sgn_c && bus.in_data[6]) begin
      ext_c = acc_d | (~64'd0 << fill_sh_c);
    end

    // 32-bit targets are re-extended from bit 31 so stray high payload bits never leak out.
    value_d = ext_c;
    if (!w64_c) begin
      value_d = sgn_c ? {{32{ext_c[31]}}, ext_c[31:0]} : {32'd0, ext_c[31:0]};
    end

    final_c = !bus.in_data[7];
    last_c  = w64_c ? (cnt_q == LAST64) : (cnt_q == 4'd4);

    // On the last permitted byte the unused payload bits must be pure extension.
    bad_c = 1'b0;
    if (last_c) begin
      if (!final_c) begin
        bad_c = 1'b1;
      end else if (w64_c) begin
        bad_c = sgn_c ? !((bus.in_data[6:0] == 7'h00) || (bus.in_data[6:0] == 7'h7F))
                      : (bus.in_data[6:1] != 6'd0);
      end else begin
        bad_c = sgn_c ? !((bus.in_data[6:3] == 4'h0) || (bus.in_data[6:3] == 4'hF))
                      : (bus.in_data[6:4] != 3'd0);
      end
    end
  end

  // Decoder FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_ACCUM;
      acc_q       <= 64'd0;
      cnt_q       <= 4'd0;
      sgn_q       <= 1'b0;
      w64_q       <= 1'b0;
      out_value_q <= 64'd0;
      out_len_q   <= 4'd0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (fire) begin
            acc_q <= acc_d;
            cnt_q <= len_d;
            sgn_q <= sgn_c;
            w64_q <= w64_c;
            if (bad_c) begin
              state_q    <= S_ERROR;
              error_q    <= 1'b1;
              in_ready_q <= 1'b0;
            end else if (final_c) begin
              state_q     <= S_OUTPUT;
              out_value_q <= value_d;
              out_len_q   <= len_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end
          end
        end
        S_OUTPUT: begin
          // out_value/out_len are left as-is after the handshake; only out_valid qualifies them.
          if (bus.out_ready) begin
            state_q     <= S_ACCUM;
            acc_q       <= 64'd0;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        S_ERROR: begin
          // A byte offered in the same cycle as clear is not taken; in_ready was low.
          if (bus.clear) begin
            state_q    <= S_ACCUM;
            acc_q      <= 64'd0;
            cnt_q      <= 4'd0;
            error_q    <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_ACCUM;
          acc_q       <= 64'd0;
          cnt_q       <= 4'd0;
          out_valid_q <= 1'b0;
          error_q     <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_value = out_value_q;
  assign bus.out_len   = out_len_q;
  assign bus.out_valid = out_valid_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Self-checking bench for leb128_decoder: directed vector table, hand-written corner
// sequences, then randomized encodings scored against an arithmetic reference model.
module tb_leb128_decoder;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  leb128_decoder_if intf ();

  leb128_decoder #(.MAX_BYTES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (intf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] b;     // byte i at [8i+7:8i]
    int          n;
    bit          sgn;
    bit          w64;
    bit          err;
    logic [63:0] val;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer value of the encoding, then a range test against the target type.
  function automatic void model(input logic [79:0] b, input int n, input bit sgn, input bit w64,
                                output bit err, output logic [63:0] val);
    logic signed [127:0] v;
    logic signed [127:0] lo;
    logic signed [127:0] hi;
    int maxlen;
    maxlen = w64 ? 10 : 5;
    v = '0;
    for (int i = 0; i < n; i++) begin
      v = v + (signed'({121'd0, b[8*i +: 7]}) <<< (7 * i));
    end
    if (sgn && b[8*(n-1) + 6]) v = v - (128'sd1 <<< (7 * n));
    if (w64) begin
      lo = sgn ? -(128'sd1 <<< 63)         : 128'sd0;
      hi = sgn ? (128'sd1 <<< 63) - 128'sd1 : (128'sd1 <<< 64) - 128'sd1;
    end else begin
      lo = sgn ? -(128'sd1 <<< 31)         : 128'sd0;
      hi = sgn ? (128'sd1 <<< 31) - 128'sd1 : (128'sd1 <<< 32) - 128'sd1;
    end
    err = (n == maxlen) && (b[8*(n-1) + 7] || (v < lo) || (v > hi));
    val = v[63:0];
  endfunction

  task automatic take();
    intf.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    intf.out_ready = 1'b0;
  endtask

  // Called at a falling edge; feeds one encoding and checks the outcome.
  task automatic do_enc(input string nm, input logic [79:0] b, input int n, input bit sgn,
                        input bit w64, input bit exp_err, input logic [63:0] exp_val,
                        input int stall);
    for (int i = 0; i < n; i++) begin
      chk({nm, " in_ready"}, 64'(intf.in_ready), 64'd1);
      intf.in_valid  = 1'b1;
      intf.in_data   = b[8*i +: 8];
      // Mode inputs after the first byte are junk; the decoder must ignore them.
      intf.is_signed = (i == 0) ? sgn : 1'($urandom);
      intf.is_64     = (i == 0) ? w64 : 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    intf.in_valid = 1'b0;
    if (exp_err) begin
      chk({nm, " error"},     64'(intf.error),     64'd1);
      chk({nm, " in_ready"},  64'(intf.in_ready),  64'd0);
      chk({nm, " out_valid"}, 64'(intf.out_valid), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk({nm, " error sticky"}, 64'(intf.error), 64'd1);
      intf.clear = 1'b1;
      @(posedge clk);
      @(negedge clk);
      intf.clear = 1'b0;
      chk({nm, " error cleared"}, 64'(intf.error),    64'd0);
      chk({nm, " ready cleared"}, 64'(intf.in_ready), 64'd1);
    end else begin
      chk({nm, " out_valid"},  64'(intf.out_valid), 64'd1);
      chk({nm, " out_value"},  intf.out_value,      exp_val);
      chk({nm, " out_len"},    64'(intf.out_len),   64'(n));
      chk({nm, " in_ready lo"}, 64'(intf.in_ready), 64'd0);
      chk({nm, " error"},      64'(intf.error),     64'd0);
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        @(negedge clk);
        chk({nm, " stall valid"}, 64'(intf.out_valid), 64'd1);
        chk({nm, " stall value"}, intf.out_value,      exp_val);
      end
      take();
      chk({nm, " valid drop"}, 64'(intf.out_valid), 64'd0);
      chk({nm, " ready back"}, 64'(intf.in_ready),  64'd1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit          merr;
    logic [63:0] mval;
    logic [79:0] rb;
    int          rn;
    bit          rs;
    bit          rw;
    int          maxlen;
    int          r;
    logic [7:0]  lb;

    checks = 0;
    errors = 0;
    intf.in_data   = 8'd0;
    intf.in_valid  = 1'b0;
    intf.is_signed = 1'b0;
    intf.is_64     = 1'b0;
    intf.out_ready = 1'b0;
    intf.clear     = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst out_valid", 64'(intf.out_valid), 64'd0);
    chk("rst out_value", intf.out_value,      64'd0);
    chk("rst out_len",   64'(intf.out_len),   64'd0);
    chk("rst error",     64'(intf.error),     64'd0);
    chk("rst in_ready",  64'(intf.in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b1;

    //            bytes                              n  s  64 err value
    tbl[0]  = '{80'h01,                              1, 0, 0, 0, 64'h1};
    tbl[1]  = '{80'h268EE5,                          3, 0, 0, 0, 64'h98765};
    tbl[2]  = '{80'h7F,                              1, 1, 0, 0, 64'hFFFFFFFFFFFFFFFF};
    tbl[3]  = '{80'h78BBC0,                          3, 1, 1, 0, 64'hFFFFFFFFFFFE1DC0};
    tbl[4]  = '{80'h7F808080808080808080,            10, 1, 1, 0, 64'h8000000000000000};
    tbl[5]  = '{80'h1080808080,                      5, 0, 0, 1, 64'h0};
    tbl[6]  = '{80'h8080808080,                      5, 0, 0, 1, 64'h0};
    tbl[7]  = '{80'h05,                              1, 0, 0, 0, 64'h5};
    tbl[8]  = '{80'h07FFFFFFFF,                      5, 1, 0, 0, 64'h000000007FFFFFFF};
    tbl[9]  = '{80'h7880808080,                      5, 1, 0, 0, 64'hFFFFFFFF80000000};
    tbl[10] = '{80'h01FFFFFFFFFFFFFFFFFF,            10, 0, 1, 0, 64'hFFFFFFFFFFFFFFFF};
    tbl[11] = '{80'h02FFFFFFFFFFFFFFFFFF,            10, 0, 1, 1, 64'h0};
    tbl[12] = '{80'h00808080808080808080,            10, 1, 1, 0, 64'h0};
    tbl[13] = '{80'h01808080808080808080,            10, 1, 1, 1, 64'h0};
    tbl[14] = '{80'h0FFFFFFFFF,                      5, 0, 0, 0, 64'h00000000FFFFFFFF};
    tbl[15] = '{80'h268EE5,                          3, 0, 1, 0, 64'h98765};
    tbl[16] = '{80'h78BBC0,                          3, 1, 0, 0, 64'hFFFFFFFFFFFE1DC0};
    tbl[17] = '{80'hFFFFFFFFFF,                      5, 1, 0, 1, 64'h0};

    for (int k = 0; k < 18; k++) begin
      do_enc($sformatf("vec%0d", k), tbl[k].b, tbl[k].n, tbl[k].sgn, tbl[k].w64,
             tbl[k].err, tbl[k].val, 0);
    end

    // Backpressure: 0x2A held for 5 cycles while the next byte waits upstream.
    intf.in_valid = 1'b1; intf.in_data = 8'h2A; intf.is_signed = 1'b0; intf.is_64 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    intf.in_data = 8'h01;
    for (int s = 0; s < 5; s++) begin
      chk("bp out_valid", 64'(intf.out_valid), 64'd1);
      chk("bp out_value", intf.out_value,      64'd42);
      chk("bp in_ready",  64'(intf.in_ready),  64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    take();
    chk("bp after valid", 64'(intf.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    intf.in_valid = 1'b0;
    chk("bp next valid", 64'(intf.out_valid), 64'd1);
    chk("bp next value", intf.out_value,      64'd1);
    chk("bp next len",   64'(intf.out_len),   64'd1);
    take();

    // clear together with a pending byte in ERROR: clear wins, byte stays pending.
    intf.in_valid = 1'b1; intf.in_data = 8'h80; intf.is_signed = 1'b0; intf.is_64 = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("clr err set", 64'(intf.error), 64'd1);
    intf.in_data = 8'h05;
    intf.clear   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    intf.clear = 1'b0;
    chk("clr err gone",  64'(intf.error),     64'd0);
    chk("clr ready",     64'(intf.in_ready),  64'd1);
    chk("clr no output", 64'(intf.out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    intf.in_valid = 1'b0;
    chk("clr byte valid", 64'(intf.out_valid), 64'd1);
    chk("clr byte value", intf.out_value,      64'd5);
    chk("clr byte len",   64'(intf.out_len),   64'd1);
    take();

    // clear outside ERROR must not disturb an encoding in progress.
    intf.clear = 1'b1;
    intf.in_valid = 1'b1; intf.in_data = 8'h80;
    @(posedge clk);
    @(negedge clk);
    intf.in_data = 8'h01;
    @(posedge clk);
    @(negedge clk);
    intf.in_valid = 1'b0;
    intf.clear = 1'b0;
    chk("noclr valid", 64'(intf.out_valid), 64'd1);
    chk("noclr value", intf.out_value,      64'd128);
    chk("noclr len",   64'(intf.out_len),   64'd2);
    take();

    // Asynchronous reset in the middle of an encoding.
    intf.in_valid = 1'b1; intf.in_data = 8'h80;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    intf.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst out_value", intf.out_value,      64'd0);
    chk("arst out_len",   64'(intf.out_len),   64'd0);
    chk("arst out_valid", 64'(intf.out_valid), 64'd0);
    chk("arst error",     64'(intf.error),     64'd0);
    chk("arst in_ready",  64'(intf.in_ready),  64'd1);
    @(negedge clk);
    reset = 1'b1;
    do_enc("arst after", 80'h03, 1, 1'b0, 1'b0, 1'b0, 64'd3, 0);

    // Randomized encodings against the reference model.
    for (int t = 0; t < 300; t++) begin
      rs = 1'($urandom);
      rw = 1'($urandom);
      maxlen = rw ? 10 : 5;
      rn = ($urandom_range(0, 2) == 0) ? maxlen : int'($urandom_range(1, maxlen));
      rb = '0;
      for (int i = 0; i < rn; i++) begin
        lb = 8'($urandom_range(0, 127));
        if (i < rn - 1) lb[7] = 1'b1;
        rb[8*i +: 8] = lb;
      end
      if (rn == maxlen) begin
        r = int'($urandom_range(0, 3));
        if (r == 0)      lb = 8'($urandom_range(128, 255));
        else if (r == 1) lb = 8'($urandom_range(0, 15));
        else if (r == 2) lb = 8'(8'h7F - 8'($urandom_range(0, 15)));
        else             lb = 8'($urandom_range(0, 127));
        rb[8*(rn-1) +: 8] = lb;
      end
      model(rb, rn, rs, rw, merr, mval);
      do_enc($sformatf("rnd%0d", t), rb, rn, rs, rw, merr, mval, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
